death_tally: RTL and testbench

Counts player deaths reported by the game logic and produces the 14-bit binary total, 0..9999, that drives the four-digit seven-segment death display. The block sits directly upstream of the display driver. It turns a level-type death indication into exactly one count per death. A respawn lockout stops a glitching or re-asserted death flag from double-counting. The total saturates at the four-digit display limit.

---
 rtl/death_tally.sv | 89 ++++++++
 tb/tb_death_tally.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/death_tally.sv
// Death counter for the four-digit display: one count per death_evt assertion,
// respawn lockout after the flag falls, saturating at MAX_COUNT.
module death_tally #(
  parameter int unsigned MAX_COUNT      = 9999,
  parameter int unsigned LOCKOUT_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        death_evt,
  input  logic        clr,
  output logic [13:0] count,
  output logic        death_pulse,
  output logic        saturated,
  output logic        armed
);

  localparam int unsigned LW = ($clog2(LOCKOUT_CYCLES + 1) > 0) ? $clog2(LOCKOUT_CYCLES + 1) : 1;
  localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES);
  localparam logic [13:0]   MAX       = 14'(MAX_COUNT);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    LOCKOUT
  } state_t;

  state_t        state, state_nxt;
  logic [LW-1:0] lock_cnt, lock_nxt;
  logic          accept;
  logic [13:0]   count_nxt;

  always_comb begin
    state_nxt = state;
    lock_nxt  = lock_cnt;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (death_evt) begin
          accept    = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (!death_evt) begin
          if (LOCKOUT_CYCLES == 0) begin
            state_nxt = IDLE;
          end else begin
            lock_nxt  = LOCK_LOAD;
            state_nxt = LOCKOUT;
          end
        end
      end
      LOCKOUT: begin
        // death_evt deliberately ignored here; the guard runs to completion
        lock_nxt = lock_cnt - LW'(1);
        if (lock_cnt == LW'(1)) state_nxt = IDLE;
      end
      default: state_nxt = HOLD;
    endcase
  end

  always_comb begin
    count_nxt = count;
    if (clr) begin
      count_nxt = '0;
    end else if (accept && (count < MAX)) begin
      count_nxt = count + 14'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HOLD;
      lock_cnt    <= '0;
      count       <= '0;
      death_pulse <= 1'b0;
      saturated   <= 1'b0;
    end else begin
      state       <= state_nxt;
      lock_cnt    <= lock_nxt;
      count       <= count_nxt;
      death_pulse <= accept;
      saturated   <= (count_nxt == MAX);
    end
  end

  assign armed = (state == IDLE);

endmodule

// File: tb/tb_death_tally.sv
// Bench for death_tally: three instances (default, MAX_COUNT=3, LOCKOUT_CYCLES=0)
// with a pulse-driven scoreboard plus directed timing checks.
module tb_death_tally;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  evt;
  logic [2:0]  clr;
  logic [13:0] c0, c1, c2;
  logic        p0, p1, p2;
  logic        s0, s1, s2;
  logic        a0, a1, a2;

  death_tally #(.MAX_COUNT(9999), .LOCKOUT_CYCLES(4)) u0 (
    .clk(clk), .rst(rst), .death_evt(evt[0]), .clr(clr[0]),
    .count(c0), .death_pulse(p0), .saturated(s0), .armed(a0));
  death_tally #(.MAX_COUNT(3), .LOCKOUT_CYCLES(4)) u1 (
    .clk(clk), .rst(rst), .death_evt(evt[1]), .clr(clr[1]),
    .count(c1), .death_pulse(p1), .saturated(s1), .armed(a1));
  death_tally #(.MAX_COUNT(9999), .LOCKOUT_CYCLES(0)) u2 (
    .clk(clk), .rst(rst), .death_evt(evt[2]), .clr(clr[2]),
    .count(c2), .death_pulse(p2), .saturated(s2), .armed(a2));

  typedef struct {
    int cnt;
    bit sat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int n_vec  = 0;
  int n_miss = 0;

  function automatic void check(string name, int act, int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endfunction

  // Monitor: every strobe must match the oldest expected accept.
  always @(negedge clk) begin
    exp_t e;
    if (p0) begin
      if (q0.size() == 0) check("u0_unexpected_pulse", 1, 0);
      else begin
        e = q0.pop_front();
        check("u0_pulse_count", int'(c0), e.cnt);
        check("u0_pulse_sat", int'(s0), int'(e.sat));
      end
    end
    if (p1) begin
      if (q1.size() == 0) check("u1_unexpected_pulse", 1, 0);
      else begin
        e = q1.pop_front();
        check("u1_pulse_count", int'(c1), e.cnt);
        check("u1_pulse_sat", int'(s1), int'(e.sat));
      end
    end
    if (p2) begin
      if (q2.size() == 0) check("u2_unexpected_pulse", 1, 0);
      else begin
        e = q2.pop_front();
        check("u2_pulse_count", int'(c2), e.cnt);
        check("u2_pulse_sat", int'(s2), int'(e.sat));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic armed_of(int id);
    case (id)
      0:       return a0;
      1:       return a1;
      default: return a2;
    endcase
  endfunction

  task automatic push(input int id, input int cnt, input bit sat);
    exp_t e;
    e.cnt = cnt;
    e.sat = sat;
    case (id)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic wait_armed(input int id, input int bound, output int n);
    n = 0;
    while (!armed_of(id) && n < bound) begin
      tick();
      n++;
    end
    if (!armed_of(id)) check("armed_timeout", 0, 1);
  endtask

  task automatic do_death(input int id, input int cnt, input bit sat);
    int n;
    wait_armed(id, 40, n);
    evt[id] = 1'b1;
    push(id, cnt, sat);
    tick();
    evt[id] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1;
    evt = '0;
    clr = '0;
    tick();
    tick();
    check("rst_count", int'(c0), 0);
    check("rst_pulse", int'(p0), 0);
    check("rst_sat", int'(s0), 0);
    check("rst_armed", int'(a0), 0);
    rst = 1'b0;
    wait_armed(0, 40, n);
    check("post_rst_arm_cycles", n, 5);

    // single death held for 10 cycles
    evt[0] = 1'b1;
    push(0, 1, 0);
    tick();
    check("accept_latency", int'(p0), 1);
    check("armed_after_accept", int'(a0), 0);
    tick();
    check("pulse_one_cycle", int'(p0), 0);
    repeat (8) tick();
    evt[0] = 1'b0;
    tick();
    tick();
    // glitch inside the lockout window
    evt[0] = 1'b1;
    tick();
    evt[0] = 1'b0;
    wait_armed(0, 40, n);
    check("lockout_len", n + 3, 5);
    check("lockout_glitch_ignored", int'(c0), 1);
    tick();
    evt[0] = 1'b1;
    push(0, 2, 0);
    tick();
    evt[0] = 1'b0;
    check("post_lockout_count", int'(c0), 2);

    // death held through reset
    wait_armed(0, 40, n);
    evt[0] = 1'b1;
    rst    = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("held_thru_rst_count", int'(c0), 0);
    check("held_thru_rst_armed", int'(a0), 0);
    evt[0] = 1'b0;
    wait_armed(0, 40, n);
    check("held_thru_rst_rearm", n, 5);

    // build to 7, then clear
    for (int k = 1; k <= 7; k++) do_death(0, k, 0);
    check("count_before_clr", int'(c0), 7);
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    check("clr_count", int'(c0), 0);
    check("clr_sat", int'(s0), 0);

    // clr coincident with accept
    wait_armed(0, 40, n);
    evt[0] = 1'b1;
    clr[0] = 1'b1;
    push(0, 0, 0);
    tick();
    evt[0] = 1'b0;
    clr[0] = 1'b0;
    check("clr_accept_count", int'(c0), 0);

    // rst together with clr in the middle of lockout
    do_death(0, 1, 0);
    tick();
    tick();
    rst    = 1'b1;
    clr[0] = 1'b1;
    tick();
    rst    = 1'b0;
    clr[0] = 1'b0;
    check("mid_lock_rst_count", int'(c0), 0);
    check("mid_lock_rst_armed", int'(a0), 0);
    wait_armed(0, 40, n);
    check("mid_lock_rst_rearm", n, 5);

    // saturation at MAX_COUNT=3
    for (int k = 1; k <= 5; k++) do_death(1, (k < 3) ? k : 3, (k >= 3));
    tick();
    check("sat_hold_count", int'(c1), 3);
    check("sat_flag", int'(s1), 1);
    clr[1] = 1'b1;
    tick();
    clr[1] = 1'b0;
    check("sat_clr_count", int'(c1), 0);
    check("sat_clr_flag", int'(s1), 0);

    // zero lockout, toggling every cycle
    wait_armed(2, 40, n);
    for (int k = 0; k < 6; k++) begin
      evt[2] = (k % 2 == 0);
      if (k % 2 == 0) push(2, k / 2 + 1, 0);
      tick();
    end
    evt[2] = 1'b0;
    check("zero_lock_toggle_count", int'(c2), 3);
    evt[2] = 1'b1;
    push(2, 4, 0);
    repeat (4) tick();
    evt[2] = 1'b0;
    tick();
    check("zero_lock_held_count", int'(c2), 4);

    repeat (3) tick();
    check("sb_drain_u0", q0.size(), 0);
    check("sb_drain_u1", q1.size(), 0);
    check("sb_drain_u2", q2.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
